// File: rtl/pcie_tx_arb_pkg.sv
// rtl/pcie_tx_arb_pkg.sv - shared states, requester indices and credit widths for the TX arbiter
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} arb_state_t;
    typedef enum logic [1:0] {CPL = 2'd0, DMA0 = 2'd1, DMA1 = 2'd2} req_idx_t;

    localparam int PH_W    = 9;
    localparam int PD_W    = 13;
    localparam int PD_CR_W = 8;
    localparam int DATA_W  = 16;

    // Top bit of each credit field flags an infinite pool.
    function automatic logic dma_eligible(
        input logic               req,
        input logic               recheck,
        input logic [PH_W-1:0]    ph,
        input logic [PD_W-1:0]    pd,
        input logic [PD_CR_W-1:0] cr
    );
        logic ph_ok;
        logic pd_ok;
        ph_ok = ph[PH_W-1] || (ph[PH_W-2:0] != '0);
        pd_ok = pd[PD_W-1] || (pd[PD_W-2:0] >= {{(PD_W-1-PD_CR_W){1'b0}}, cr});
        return req && !recheck && ph_ok && pd_ok;
    endfunction

endpackage

// File: rtl/pcie_tx_arb_rr.sv
// rtl/pcie_tx_arb_rr.sv - two-way round-robin pick between the DMA engines
module pcie_tx_arb_rr (
    input  logic       clk_125,
    input  logic       sys_rst,
    input  logic [1:0] elig,
    input  logic       take,
    output logic       valid,
    output logic       pick
);

    logic ptr;

    assign valid = |elig;
    assign pick  = (elig == 2'b11) ? ptr : elig[1];

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/pcie_tx_arb.sv
// rtl/pcie_tx_arb.sv - TX port arbiter: completion engine first, then round-robin DMA, with watchdog
module pcie_tx_arb
    import pcie_tx_arb_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic               clk_125,
    input  logic               sys_rst,
    input  logic               cpl_req,
    output logic               cpl_gnt,
    input  logic               cpl_st,
    input  logic               cpl_end,
    input  logic [DATA_W-1:0]  cpl_data,
    input  logic               dma0_req,
    input  logic [PD_CR_W-1:0] dma0_pd_cr,
    output logic               dma0_gnt,
    input  logic               dma0_st,
    input  logic               dma0_end,
    input  logic [DATA_W-1:0]  dma0_data,
    input  logic               dma1_req,
    input  logic [PD_CR_W-1:0] dma1_pd_cr,
    output logic               dma1_gnt,
    input  logic               dma1_st,
    input  logic               dma1_end,
    input  logic [DATA_W-1:0]  dma1_data,
    output logic               tx_req,
    input  logic               tx_rdy,
    output logic               tx_st,
    output logic               tx_end,
    output logic [DATA_W-1:0]  tx_data,
    input  logic [PH_W-1:0]    tx_ca_ph,
    input  logic [PD_W-1:0]    tx_ca_pd,
    input  logic               tx_ca_p_recheck,
    output logic               err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t      state;
    req_idx_t        winner;
    logic [WD_W-1:0] wd;
    logic [2:0]      gnt_q;
    logic [1:0]      elig;
    logic            rr_valid;
    logic            rr_pick;
    logic            rr_take;
    logic            wd_hit;

    assign elig[0] = dma_eligible(dma0_req, tx_ca_p_recheck, tx_ca_ph, tx_ca_pd, dma0_pd_cr);
    assign elig[1] = dma_eligible(dma1_req, tx_ca_p_recheck, tx_ca_ph, tx_ca_pd, dma1_pd_cr);
    assign rr_take = (state == IDLE) && !cpl_req && rr_valid;
    assign wd_hit  = (wd == WD_W'(TIMEOUT));

    assign cpl_gnt  = gnt_q[CPL];
    assign dma0_gnt = gnt_q[DMA0];
    assign dma1_gnt = gnt_q[DMA1];

    pcie_tx_arb_rr u_rr (
        .clk_125 (clk_125),
        .sys_rst (sys_rst),
        .elig    (elig),
        .take    (rr_take),
        .valid   (rr_valid),
        .pick    (rr_pick)
    );

    // Zero-latency data path so the owner's beats reach the core in the cycle it drives them.
    always_comb begin
        tx_st   = 1'b0;
        tx_end  = 1'b0;
        tx_data = '0;
        if (state == XFER) begin
            case (winner)
                CPL: begin
                    tx_st   = cpl_st;
                    tx_end  = cpl_end;
                    tx_data = cpl_data;
                end
                DMA0: begin
                    tx_st   = dma0_st;
                    tx_end  = dma0_end;
                    tx_data = dma0_data;
                end
                DMA1: begin
                    tx_st   = dma1_st;
                    tx_end  = dma1_end;
                    tx_data = dma1_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state       <= IDLE;
            winner      <= CPL;
            wd          <= '0;
            gnt_q       <= '0;
            tx_req      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (cpl_req) begin
                        winner <= CPL;
                        state  <= REQ;
                        tx_req <= 1'b1;
                    end else if (rr_valid) begin
                        winner <= rr_pick ? DMA1 : DMA0;
                        state  <= REQ;
                        tx_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (wd_hit) begin
                        state       <= IDLE;
                        tx_req      <= 1'b0;
                        gnt_q       <= '0;
                        wd          <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                        if (tx_rdy) begin
                            state         <= XFER;
                            gnt_q         <= '0;
                            gnt_q[winner] <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    // An end beat outranks a watchdog expiry in the same cycle.
                    if (tx_end) begin
                        state  <= GAP;
                        gnt_q  <= '0;
                        tx_req <= 1'b0;
                    end else if (wd_hit) begin
                        state       <= IDLE;
                        tx_req      <= 1'b0;
                        gnt_q       <= '0;
                        wd          <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                        if (tx_st) begin
                            tx_req <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    wd    <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pcie_tx_arb.md
PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles allowed in REQ plus XFER before the arbiter aborts.
REQ-002 clk_125  input  1  the single system clock, 125 MHz, from the PCIe core.
REQ-003 sys_rst  input  1  reset, synchronous and active-high.
REQ-004 cpl_req  input  1  completion engine requests the TX port.
REQ-005 cpl_gnt  output  1  completion engine owns the TX port.
REQ-006 cpl_st, cpl_end  input  1 each  completion engine start-of-TLP and end-of-TLP beat markers.
REQ-007 cpl_data  input  16  completion engine TLP data.
REQ-008 dmaN_req  input  1  DMA write engine N (N=0,1) requests the TX port.
REQ-009 dmaN_pd_cr  input  8  posted-data credits the pending DMA TLP needs.
REQ-010 dmaN_gnt  output  1  DMA engine N owns the TX port.
REQ-011 dmaN_st, dmaN_end  input  1 each  DMA engine N start and end beat markers.
REQ-012 dmaN_data  input  16  DMA engine N TLP data.
REQ-013 tx_req  output  1  TX request to the PCIe core.
REQ-014 tx_rdy  input  1  TX ready from the PCIe core.
REQ-015 tx_st, tx_end  output  1 each  start and end beat markers to the core.
REQ-016 tx_data  output  16  TLP data to the core.
REQ-017 tx_ca_ph  input  9  posted-header credits available; bit 8 set means infinite.
REQ-018 tx_ca_pd  input  13  posted-data credits available; bit 12 set means infinite.
REQ-019 tx_ca_p_recheck  input  1  credit values are being recomputed this cycle.
REQ-020 err_timeout  output  1  one-cycle pulse when a watchdog abort occurs.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, XFER and GAP.
REQ-022 In IDLE, the arbiter SHALL pick a winner in this order: cpl_req first; otherwise round-robin between eligible DMA engines.
REQ-023 DMA engine N SHALL be eligible only when all of the following hold:
- dmaN_req=1;
- tx_ca_p_recheck=0;
- tx_ca_ph[8]=1 or tx_ca_ph[7:0]!=0;
- tx_ca_pd[12]=1 or tx_ca_pd[11:0] >= the zero-extended dmaN_pd_cr.
REQ-024 The round-robin pointer SHALL toggle only when a DMA grant is issued; cpl grants SHALL leave it unchanged; its reset value SHALL be 0, so dma0 wins the first tie.
REQ-025 When a winner exists, IDLE SHALL register the winner and move to REQ; tx_req SHALL be 1 from the next cycle.
REQ-026 In REQ, the arbiter SHALL hold tx_req and move to XFER on the first cycle with tx_rdy=1.
REQ-027 The winner's gnt SHALL be 1 in every XFER cycle and 0 otherwise; at most one gnt SHALL be high at any time.
REQ-028 In XFER, tx_st, tx_end and tx_data SHALL be a combinational (zero-latency) mux of the winner's inputs.
REQ-029 Outside XFER, tx_st, tx_end and tx_data SHALL be 0.
REQ-030 tx_req SHALL fall in the cycle after the muxed tx_st=1 is seen.
REQ-031 A single-beat TLP (st=1 and end=1 in the same cycle) SHALL be accepted.
REQ-032 The cycle in which the muxed tx_end=1 SHALL move the FSM to GAP; GAP SHALL last exactly one cycle and then go to IDLE, giving a minimum one-cycle gap between TLPs.
REQ-033 A requester dropping req in REQ or XFER SHALL NOT change the winner or the state.
REQ-034 New or withdrawn requests SHALL be sampled only in IDLE.
REQ-035 A watchdog counter SHALL clear in IDLE and increment in REQ and XFER.
REQ-036 When the watchdog reaches TIMEOUT, the arbiter SHALL, in the next cycle: pulse err_timeout, drop tx_req and gnt, and enter IDLE.
REQ-037 A tx_end and a timeout in the same cycle SHALL be treated as a normal end, with no err_timeout pulse.

Reset
REQ-038 On sys_rst=1 at a clk_125 edge, the arbiter SHALL return to IDLE, clear the watchdog and RR pointer, and drive every output to 0, including mid-transfer.
REQ-039 Reset SHALL take effect in that same cycle's register update; there is no asynchronous path.

Structure
REQ-040 State encodings, the requester-index constants (CPL=0, DMA0=1, DMA1=2) and the credit-field widths SHALL live in a shared package used by the DMA engines.
REQ-041 One sub-module, pcie_tx_arb_rr, SHALL hold the two-way round-robin pick and its pointer.
REQ-042 The FSM, mux and watchdog SHALL remain in pcie_tx_arb.

Verification
REQ-043 Scenario 1: cpl_req, dma0_req and dma1_req all rise together, with infinite credits and tx_rdy=1 two cycles after tx_req -> grant order cpl, dma0, dma1, with exactly one GAP cycle between TLPs.
REQ-044 Scenario 2: dma0_pd_cr=16, tx_ca_pd=8, dma1_pd_cr=4 -> dma1 is granted and dma0 waits; once tx_ca_pd is raised to 16, dma0 is granted.
REQ-045 Scenario 3: a single-beat cpl TLP with data 16'hA5A5 -> tx_st=1, tx_end=1 and tx_data=16'hA5A5 in the same cycle; tx_req falls the next cycle.
REQ-046 Scenario 4: tx_rdy held 0 for 1030 cycles with TIMEOUT=1023 -> err_timeout pulses once, tx_req falls, and the FSM returns to IDLE.
REQ-047 Scenario 5: sys_rst asserted in the third beat of a DMA TLP -> the next cycle has all outputs 0 and the FSM in IDLE; a fresh dma1_req is then granted before dma0 (RR pointer=0, only dma1 requesting).
REQ-048 Scenario 6: tx_ca_p_recheck=1 while dma0_req=1 -> no DMA grant that cycle; a grant follows once recheck clears.
